// File: rtl/sky_xu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the handshaked execute-unit ALU.
package sky_xu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHU  = 5'd12,
    OP_MULHSU = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  // out_flags = {illegal, negative, carry, overflow, zero}
  localparam int FLG_ZERO  = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_NEG   = 3;
  localparam int FLG_ILL   = 4;

  typedef enum logic [1:0] {IDLE, MUL, DIV} alu_state_e;

endpackage

// File: rtl/sky_xalu_div.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes, sign fix-up on exit.
// done_o is asserted during the last iteration; quo_o/rem_o already carry that iteration's result.
module sky_xalu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, qneg_q, rneg_q, dz_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, a_q;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic [WIDTH:0]   shl, diff;
  logic             a_neg, b_neg;

  assign a_neg = signed_i && a_i[WIDTH-1];
  assign b_neg = signed_i && b_i[WIDTH-1];

  assign shl   = {rem_q, quo_q[WIDTH-1]};
  assign diff  = shl - {1'b0, dvs_q};
  assign quo_n = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_n = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  // Divide-by-zero bypasses the sign fix-up; MIN/-1 falls out of the magnitude path naturally.
  assign quo_o  = dz_q ? '1  : (qneg_q ? -quo_n : quo_n);
  assign rem_o  = dz_q ? a_q : (rneg_q ? -rem_n : rem_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= a_neg ? -a_i : a_i;
      rem_q  <= '0;
      dvs_q  <= b_neg ? -b_i : b_i;
      a_q    <= a_i;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= (b_i == '0);
    end else if (busy_q) begin
      busy_q <= !done_o;
      cnt_q  <= cnt_q + CW'(1);
      quo_q  <= quo_n;
      rem_q  <= rem_n;
    end
  end

endmodule

// File: rtl/sky_xalu.sv
// Handshaked integer ALU: single-cycle logic/arith, iterative shift-add multiplier kept inline.
// Define SKY_XALU_DIV_EN to build DIV/DIVU/REM/REMU; otherwise those opcodes report illegal.
module sky_xalu import sky_xu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags
);
  localparam int SHW   = $clog2(WIDTH);
  localparam int MUL_N = WIDTH / MUL_BPC;
  localparam int MCW   = $clog2(MUL_N + 1);

  alu_state_e         state_q, state_d;
  alu_op_e            op, op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_result_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [4:0]         out_flags_q;
  logic               accept, is_mul, is_div;

  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, prod;
  logic [WIDTH-1:0]   mplier_q, mag_a, mag_b;
  logic               mneg_q, a_sgn, b_sgn;
  logic [MCW-1:0]     mcnt_q;

  logic               fin_vld;
  logic [WIDTH-1:0]   fin_res;
  logic [TAG_W-1:0]   fin_tag;
  logic [4:0]         fin_flags;

  function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic ill, c, v);
    logic [4:0] f;
    f            = '0;
    f[FLG_ZERO]  = (r == '0);
    f[FLG_NEG]   = r[WIDTH-1];
    f[FLG_CARRY] = c;
    f[FLG_OVF]   = v;
    f[FLG_ILL]   = ill;
    return f;
  endfunction

  assign op       = alu_op_e'(in_op);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
`ifdef SKY_XALU_DIV_EN
  assign is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`else
  assign is_div   = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

  always_comb begin
    add_w   = {1'b0, in_a} + {1'b0, in_b};
    sub_w   = {1'b0, in_a} - {1'b0, in_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << in_b[SHW-1:0];
      OP_SRL:  alu_res = in_a >> in_b[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      default: alu_ill = !(is_mul || is_div);
    endcase
  end

  // Multiply magnitudes, then negate the 2*WIDTH product once at the end.
  always_comb begin
    a_sgn = (op == OP_MULH || op == OP_MULHSU) && in_a[WIDTH-1];
    b_sgn = (op == OP_MULH) && in_b[WIDTH-1];
    mag_a = a_sgn ? -in_a : in_a;
    mag_b = b_sgn ? -in_b : in_b;
    acc_d = acc_q;
    for (int j = 0; j < MUL_BPC; j++)
      if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
    prod  = mneg_q ? -acc_d : acc_d;
  end

`ifdef SKY_XALU_DIV_EN
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  sky_xalu_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept && is_div),
    .signed_i (op == OP_DIV || op == OP_REM),
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (div_done),
    .quo_o    (div_quo),
    .rem_o    (div_rem)
  );
`endif

  always_comb begin
    state_d   = state_q;
    fin_vld   = 1'b0;
    fin_res   = '0;
    fin_tag   = tag_q;
    fin_flags = '0;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul)      state_d = MUL;
        else if (is_div) state_d = DIV;
        else begin
          fin_vld   = 1'b1;
          fin_res   = alu_res;
          fin_tag   = in_tag;
          fin_flags = mk_flags(alu_res, alu_ill, alu_c, alu_v);
        end
      end
      MUL: if (mcnt_q == MCW'(MUL_N - 1)) begin
        state_d   = IDLE;
        fin_vld   = 1'b1;
        fin_res   = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        fin_flags = mk_flags(fin_res, 1'b0, 1'b0, 1'b0);
      end
`ifdef SKY_XALU_DIV_EN
      DIV: if (div_done) begin
        state_d   = IDLE;
        fin_vld   = 1'b1;
        fin_res   = (op_q == OP_DIV || op_q == OP_DIVU) ? div_quo : div_rem;
        fin_flags = mk_flags(fin_res, 1'b0, 1'b0, 1'b0);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      mneg_q       <= 1'b0;
      mcnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (fin_vld) begin
        out_valid_q  <= 1'b1;
        out_result_q <= fin_res;
        out_tag_q    <= fin_tag;
        out_flags_q  <= fin_flags;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
      if (accept) begin
        op_q  <= op;
        tag_q <= in_tag;
      end
      if (accept && is_mul) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
        mplier_q <= mag_b;
        mneg_q   <= a_sgn ^ b_sgn;
        mcnt_q   <= '0;
      end else if (state_q == MUL) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << MUL_BPC;
        mplier_q <= mplier_q >> MUL_BPC;
        mcnt_q   <= mcnt_q + MCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sky_xalu.sv
// Directed bench for sky_xalu with an arithmetic reference model and a per-cycle output compare.
module tb_sky_xalu;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [4:0]    in_op = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic [4:0]    out_flags;

  int checks = 0, errors = 0, cyc = 0, last_acc = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  f;
    logic [3:0]  t;
  } exp_t;
  exp_t q[$];

  sky_xalu #(.WIDTH(W), .TAG_W(TW), .MUL_BPC(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: {flags, result} straight from the arithmetic definition of each op.
  function automatic logic [36:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [63:0] p;
    logic [31:0] r;
    logic c, v, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      5'd0:  begin s = sa + sb; r = a + b; p = {32'b0, a} + {32'b0, b}; c = p[32]; v = (s != longint'($signed(r))); end
      5'd1:  begin s = sa - sb; r = a - b; c = (a < b); v = (s != longint'($signed(r))); end
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = sa * sb; r = p[31:0]; end
      5'd11: begin p = sa * sb; r = p[63:32]; end
      5'd12: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      5'd13: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
`ifdef SKY_XALU_DIV_EN
      5'd14: begin if (b == 0) r = '1; else begin s = sa / sb; r = s[31:0]; end end
      5'd15: r = (b == 0) ? '1 : a / b;
      5'd16: begin if (b == 0) r = a; else begin s = sa % sb; r = s[31:0]; end end
      5'd17: r = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r[31], c, v, (r == 0), r};
  endfunction

  // Every cycle the output is valid it must equal the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out got=%0h", out_result);
      end else begin
        chk("cmp_result", out_result, q[0].r);
        chk("cmp_flags", out_flags, q[0].f);
        chk("cmp_tag", out_tag, q[0].t);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) q.delete();
    else if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    logic [36:0] m;
    exp_t e;
    int n;
    in_op = op; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%0d", op);
      in_valid = 1'b0;
      return;
    end
    m = model(op, a, b);
    e.r = m[31:0]; e.f = m[36:32]; e.t = t;
    q.push_back(e);
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_op = 5'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
  endtask

  task automatic wait_valid(input string nm, input int exp_lat, input bit busy_chk);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      if (busy_chk) chk({nm, "_in_ready_busy"}, in_ready, 0);
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, cyc - last_acc + 1, exp_lat);
  endtask

  initial begin
    int first, n;

    // model pinned against hand-computed values
    chk("model_add", model(5'd0, 32'h7FFFFFFF, 32'h1), {5'b01010, 32'h80000000});
    chk("model_mulhu", model(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF), {5'b01000, 32'hFFFFFFFE});
    chk("model_mulhsu", model(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF), {5'b01000, 32'hFFFFFFFF});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);

    issue(5'd0, 32'h7FFFFFFF, 32'h1, 4'd3);
    wait_valid("add", 1, 0);
    chk("add_res", out_result, 32'h80000000);
    chk("add_flags", out_flags, 5'b01010);
    chk("add_tag", out_tag, 3);

    issue(5'd1, 32'h0, 32'h1, 4'd4);
    wait_valid("sub", 1, 0);
    chk("sub_res", out_result, 32'hFFFFFFFF);
    chk("sub_flags", out_flags, 5'b01100);
    issue(5'd1, 32'd5, 32'd5, 4'd4);
    wait_valid("sub0", 1, 0);
    chk("sub0_res", out_result, 0);
    chk("sub0_flags", out_flags, 5'b00001);

    issue(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5);
    wait_valid("mulh", 17, 1);
    chk("mulh_res", out_result, 0);
    chk("mulh_flags", out_flags, 5'b00001);
    issue(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6);
    wait_valid("mulhu", 17, 1);
    chk("mulhu_res", out_result, 32'hFFFFFFFE);

    // backpressure: result must hold and input side stay closed
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(5'd10, 32'd6, 32'd7, 4'd9);
    wait_valid("mul_bp", 17, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", out_result, 32'd42);
      chk("bp_tag", out_tag, 9);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);

    // back-to-back single-cycle ops, including an illegal opcode
    issue(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd1);
    first = last_acc;
    issue(5'd3, 32'hF000_0000, 32'h0000_000F, 4'd2);
    issue(5'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 4'd3);
    issue(5'd5, 32'h0000_0001, 32'h0000_003F, 4'd4);
    issue(5'd6, 32'h8000_0000, 32'h0000_0004, 4'd5);
    issue(5'd7, 32'h8000_0000, 32'h0000_0004, 4'd6);
    issue(5'd8, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7);
    issue(5'd9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd8);
    issue(5'd20, 32'h1234_5678, 32'h1, 4'd9);
    chk("b2b_throughput", last_acc - first, 8);
    wait_valid("illegal20", 1, 0);
    chk("illegal20_flags", out_flags, 5'b10001);

    issue(5'd10, 32'hFFFF_FFFD, 32'd5, 4'd10);
    issue(5'd11, 32'h8000_0000, 32'h8000_0000, 4'd11);
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd12);
    issue(5'd13, 32'h0000_0003, 32'h8000_0000, 4'd13);

`ifdef SKY_XALU_DIV_EN
    issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1);
    wait_valid("div_ovf", 33, 1);
    chk("div_ovf_res", out_result, 32'h80000000);
    chk("div_ovf_flags", out_flags, 5'b01000);
    issue(5'd15, 32'd7, 32'd0, 4'd2);
    wait_valid("divu0", 33, 1);
    chk("divu0_res", out_result, 32'hFFFFFFFF);
    issue(5'd16, 32'd7, 32'd0, 4'd3);
    wait_valid("rem0", 33, 1);
    chk("rem0_res", out_result, 32'd7);
    issue(5'd14, 32'hFFFF_FFF9, 32'd2, 4'd4);
    issue(5'd16, 32'hFFFF_FFF9, 32'd2, 4'd5);
    issue(5'd17, 32'd100, 32'd7, 4'd6);
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);
`else
    issue(5'd14, 32'd7, 32'd2, 4'd1);
    wait_valid("op14_illegal", 1, 0);
    chk("op14_res", out_result, 0);
    chk("op14_flags", out_flags, 5'b10001);
`endif

    // reset in the middle of a multiply
    issue(5'd12, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    issue(5'd0, 32'd2, 32'd3, 4'd2);
    wait_valid("post_rst_add", 1, 0);
    chk("post_rst_res", out_result, 32'd5);

    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
